// File: rtl/csr_types.sv
// Shared CSR arbiter types: operation encodings, FSM states, the latched request
// record and the read-modify-write helpers used by the arbiter datapath.
package csr_types;

    localparam int CSR_ADDR_BITS = 12;
    localparam int NW_BITS       = 2;
    localparam int UUID_BITS     = 8;

    localparam logic [CSR_ADDR_BITS-1:0] CSR_MSCRATCH = 12'h340;

    typedef enum logic [1:0] {
        CSR_RO = 2'b00,
        CSR_RW = 2'b01,
        CSR_RS = 2'b10,
        CSR_RC = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RSP
    } csr_state_e;

    typedef struct packed {
        csr_op_e                  op;
        logic [CSR_ADDR_BITS-1:0] addr;
        logic [NW_BITS-1:0]       wid;
        logic [UUID_BITS-1:0]     uuid;
        logic [31:0]              data;
    } csr_req_t;

    // Set/clear with an empty mask leaves the CSR untouched, so the write is skipped.
    function automatic logic csr_needs_write(csr_op_e op, logic [31:0] data);
        return (op == CSR_RW) || ((op != CSR_RO) && (data != 32'd0));
    endfunction

    function automatic logic [31:0] csr_rmw(csr_op_e op, logic [31:0] old_val, logic [31:0] data);
        case (op)
            CSR_RW:  return data;
            CSR_RS:  return old_val | data;
            CSR_RC:  return old_val & ~data;
            default: return old_val;
        endcase
    endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin request selector: grants the lowest requesting index at or above
// rr_ptr (wrapping), and advances rr_ptr past the winner on every grant.
module vx_rr_arbiter #(
    parameter int NUM_REQS = 2,
    parameter int IDX_W    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] requests,
    input  logic                enable,
    output logic [NUM_REQS-1:0] grant_onehot,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                grant_valid
);

    logic [IDX_W-1:0] rr_ptr;

    // NOTE: every output gets a default before the search so no path infers a latch.
    always_comb begin
        int j;
        grant_onehot = '0;
        grant_idx    = '0;
        grant_valid  = 1'b0;
        j            = 0;
        if (enable) begin
            // Walk from the farthest offset down so the nearest requester wins last.
            for (int i = NUM_REQS - 1; i >= 0; i--) begin
                j = int'(rr_ptr) + i;
                if (j >= NUM_REQS) j = j - NUM_REQS;
                if (requests[j]) begin
                    grant_onehot    = '0;
                    grant_onehot[j] = 1'b1;
                    grant_idx       = IDX_W'(j);
                    grant_valid     = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (int'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/vx_csr_arbiter.sv
// Shares one CSR data block between NUM_REQS requesters: arbitrate, read,
// optionally write back the read-modify-write result, then return the old value.
module vx_csr_arbiter
    import csr_types::*;
#(
    parameter int NUM_REQS = 2,
    localparam int IDX_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic [NUM_REQS-1:0]                  req_valid,
    output logic [NUM_REQS-1:0]                  req_ready,
    input  logic [NUM_REQS-1:0][1:0]             req_op,
    input  logic [NUM_REQS-1:0][CSR_ADDR_BITS-1:0] req_addr,
    input  logic [NUM_REQS-1:0][NW_BITS-1:0]     req_wid,
    input  logic [NUM_REQS-1:0][UUID_BITS-1:0]   req_uuid,
    input  logic [NUM_REQS-1:0][31:0]            req_data,

    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [IDX_W-1:0]                     rsp_idx,
    output logic [31:0]                          rsp_data,

    output logic                                 read_enable,
    output logic [CSR_ADDR_BITS-1:0]             read_addr,
    output logic [NW_BITS-1:0]                   read_wid,
    output logic [UUID_BITS-1:0]                 read_uuid,
    input  logic [31:0]                          read_data,

    output logic                                 write_enable,
    output logic [CSR_ADDR_BITS-1:0]             write_addr,
    output logic [NW_BITS-1:0]                   write_wid,
    output logic [UUID_BITS-1:0]                 write_uuid,
    output logic [31:0]                          write_data,

    output logic                                 busy
);

    csr_state_e          state;
    csr_req_t            req_r;
    logic [IDX_W-1:0]    idx_r;
    logic [31:0]         old_r;

    logic [NUM_REQS-1:0] grant_onehot;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_valid;
    logic                arb_enable;

    // Gating with reset keeps req_ready low while reset is held.
    assign arb_enable = (state == ST_IDLE) && !reset;

    vx_rr_arbiter #(
        .NUM_REQS (NUM_REQS),
        .IDX_W    (IDX_W)
    ) u_rr_arbiter (
        .clk          (clk),
        .reset        (reset),
        .requests     (req_valid),
        .enable       (arb_enable),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid)
    );

    assign req_ready  = grant_onehot;

    assign read_addr  = req_r.addr;
    assign read_wid   = req_r.wid;
    assign read_uuid  = req_r.uuid;
    assign write_addr = req_r.addr;
    assign write_wid  = req_r.wid;
    assign write_uuid = req_r.uuid;
    assign rsp_idx    = idx_r;
    assign rsp_data   = old_r;

    // NOTE: the latched request fields are plain registers, so they are cleared on reset like the rest.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            req_r        <= '0;
            idx_r        <= '0;
            old_r        <= '0;
            write_data   <= '0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            rsp_valid    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        req_r.op    <= csr_op_e'(req_op[grant_idx]);
                        req_r.addr  <= req_addr[grant_idx];
                        req_r.wid   <= req_wid[grant_idx];
                        req_r.uuid  <= req_uuid[grant_idx];
                        req_r.data  <= req_data[grant_idx];
                        idx_r       <= grant_idx;
                        read_enable <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_READ;
                    end
                end
                ST_READ: begin
                    read_enable <= 1'b0;
                    old_r       <= read_data;
                    if (csr_needs_write(req_r.op, req_r.data)) begin
                        write_enable <= 1'b1;
                        write_data   <= csr_rmw(req_r.op, read_data, req_r.data);
                        state        <= ST_WRITE;
                    end else begin
                        rsp_valid <= 1'b1;
                        state     <= ST_RSP;
                    end
                end
                ST_WRITE: begin
                    write_enable <= 1'b0;
                    rsp_valid    <= 1'b1;
                    state        <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vx_csr_arbiter.sv
// Directed bench for vx_csr_arbiter: a CSR memory model answers reads, stimulus
// pushes expected responses, and a monitor checks each response handshake.
module tb_vx_csr_arbiter;
    import csr_types::*;

    localparam int N = 2;

    logic                             clk = 1'b0;
    logic                             reset = 1'b1;
    logic [N-1:0]                     req_valid = '0;
    logic [N-1:0]                     req_ready;
    logic [N-1:0][1:0]                req_op = '0;
    logic [N-1:0][CSR_ADDR_BITS-1:0]  req_addr = '0;
    logic [N-1:0][NW_BITS-1:0]        req_wid = '0;
    logic [N-1:0][UUID_BITS-1:0]      req_uuid = '0;
    logic [N-1:0][31:0]               req_data = '0;
    logic                             rsp_valid;
    logic                             rsp_ready = 1'b1;
    logic [0:0]                       rsp_idx;
    logic [31:0]                      rsp_data;
    logic                             read_enable;
    logic [CSR_ADDR_BITS-1:0]         read_addr;
    logic [NW_BITS-1:0]               read_wid;
    logic [UUID_BITS-1:0]             read_uuid;
    logic [31:0]                      read_data;
    logic                             write_enable;
    logic [CSR_ADDR_BITS-1:0]         write_addr;
    logic [NW_BITS-1:0]               write_wid;
    logic [UUID_BITS-1:0]             write_uuid;
    logic [31:0]                      write_data;
    logic                             busy;

    vx_csr_arbiter #(.NUM_REQS(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wid      (req_wid),
        .req_uuid     (req_uuid),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_idx      (rsp_idx),
        .rsp_data     (rsp_data),
        .read_enable  (read_enable),
        .read_addr    (read_addr),
        .read_wid     (read_wid),
        .read_uuid    (read_uuid),
        .read_data    (read_data),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_wid    (write_wid),
        .write_uuid   (write_uuid),
        .write_data   (write_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // CSR data block model: combinational read, write on the clock edge.
    logic [31:0] csr_mem [0:4095];
    assign read_data = csr_mem[read_addr];
    always @(posedge clk) if (write_enable) csr_mem[write_addr] <= write_data;

    typedef struct packed {
        logic [0:0]  idx;
        logic [31:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic [UUID_BITS-1:0] uuid_ctr = 8'h10;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: every accepted response must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got idx=%0d data=0x%0h, required no response", rsp_idx, rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_idx", 64'(rsp_idx), 64'(mon_e.idx));
                check("rsp_data", 64'(rsp_data), 64'(mon_e.data));
            end
        end
    end

    // One isolated request with cycle-exact read/write/response checks; called #1 after a clock edge with the FSM idle.
    task automatic single_op(input int idx, input logic [1:0] op, input logic [11:0] addr,
                             input logic [31:0] data, input logic [31:0] old_v,
                             input logic [31:0] exp_wd, input bit has_write);
        uuid_ctr++;
        req_op[idx]   = op;
        req_addr[idx] = addr;
        req_data[idx] = data;
        req_wid[idx]  = NW_BITS'(idx + 1);
        req_uuid[idx] = uuid_ctr;
        req_valid     = '0;
        req_valid[idx] = 1'b1;
        #1;
        check("grant_onehot", 64'(req_ready), 64'(1) << idx);
        exp_q.push_back('{idx: 1'(idx), data: old_v});
        @(posedge clk); #1;
        req_valid = '0;
        check("rd_en_T1", 64'(read_enable), 64'(1));
        check("rd_addr_T1", 64'(read_addr), 64'(addr));
        check("rd_uuid_T1", 64'(read_uuid), 64'(uuid_ctr));
        check("wr_en_T1", 64'(write_enable), 64'(0));
        check("busy_T1", 64'(busy), 64'(1));
        @(posedge clk); #1;
        check("rd_en_T2", 64'(read_enable), 64'(0));
        if (has_write) begin
            check("wr_en_T2", 64'(write_enable), 64'(1));
            check("wr_data_T2", 64'(write_data), 64'(exp_wd));
            check("wr_wid_T2", 64'(write_wid), 64'(idx + 1));
            check("rsp_valid_T2", 64'(rsp_valid), 64'(0));
            @(posedge clk); #1;
            check("wr_en_T3", 64'(write_enable), 64'(0));
        end else begin
            check("wr_en_skip", 64'(write_enable), 64'(0));
        end
        check("rsp_valid_on_time", 64'(rsp_valid), 64'(1));
        @(posedge clk); #1;
        check("busy_after_rsp", 64'(busy), 64'(0));
        check("rsp_valid_after_rsp", 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int guard;
        int last_cyc;
        int cnt0;
        int cnt1;
        logic [N-1:0] exp_oh;

        for (int a = 0; a < 4096; a++) csr_mem[a] = 32'd0;
        csr_mem[CSR_MSCRATCH] = 32'h0000_1234;
        csr_mem[12'h300]      = 32'h0000_00F0;
        csr_mem[12'h301]      = 32'h0000_0055;
        csr_mem[12'h302]      = 32'hAAAA_0002;
        csr_mem[12'h303]      = 32'hBBBB_0003;
        csr_mem[12'h304]      = 32'h0000_0777;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_read_enable", 64'(read_enable), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_req_ready", 64'(req_ready), 64'(0));
        check("post_rst_read_addr", 64'(read_addr), 64'(0));

        // Single RW: old 0x1234 returned, new value written at T+2.
        single_op(0, CSR_RW, CSR_MSCRATCH, 32'hA5A5_0000, 32'h0000_1234, 32'hA5A5_0000, 1'b1);
        check("mscratch_written", 64'(csr_mem[CSR_MSCRATCH]), 64'hA5A5_0000);

        // RS then RC on the same CSR.
        single_op(0, CSR_RS, 12'h300, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b1);
        single_op(1, CSR_RC, 12'h300, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F, 1'b1);

        // RS with an empty mask: no write, response at T+2.
        single_op(1, CSR_RS, 12'h301, 32'h0, 32'h0000_0055, 32'h0, 1'b0);

        // Fairness: both requesters valid continuously, read-only ops.
        req_op[0] = CSR_RO; req_addr[0] = 12'h302; req_data[0] = '0;
        req_op[1] = CSR_RO; req_addr[1] = 12'h303; req_data[1] = '0;
        req_valid = 2'b11;
        cnt0 = 0; cnt1 = 0; last_cyc = 0;
        #1;
        for (int k = 0; k < 8; k++) begin
            guard = 0;
            while (req_ready == '0 && guard < 10) begin
                @(posedge clk); #1;
                guard++;
            end
            exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            check("fair_grant", 64'(req_ready), 64'(exp_oh));
            if (k > 0) check("fair_period", 64'(cyc - last_cyc), 64'(3));
            last_cyc = cyc;
            if (req_ready[0]) cnt0++;
            if (req_ready[1]) cnt1++;
            exp_q.push_back((k % 2 == 0) ? '{idx: 1'b0, data: 32'hAAAA_0002}
                                         : '{idx: 1'b1, data: 32'hBBBB_0003});
            @(posedge clk); #1;
        end
        req_valid = '0;
        check("fair_count0", 64'(cnt0), 64'(4));
        check("fair_count1", 64'(cnt1), 64'(4));
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: response held for 5 cycles while requester 1 waits.
        rsp_ready = 1'b0;
        req_op[0] = CSR_RO; req_addr[0] = 12'h301;
        req_valid = 2'b11;
        exp_q.push_back('{idx: 1'b0, data: 32'h0000_0055});
        @(posedge clk); #1;
        guard = 0;
        while (!rsp_valid && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
            check("bp_rsp_idx", 64'(rsp_idx), 64'(0));
            check("bp_rsp_data", 64'(rsp_data), 64'h55);
            check("bp_req_ready", 64'(req_ready), 64'(0));
            check("bp_busy", 64'(busy), 64'(1));
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_grant_after_rsp", 64'(req_ready), 64'(2'b10));
        check("bp_busy_after_rsp", 64'(busy), 64'(0));
        req_valid = '0;
        @(posedge clk); #1;

        // Reset asserted during the WRITE cycle aborts the request.
        req_op[0] = CSR_RW; req_addr[0] = 12'h304; req_data[0] = 32'hDEAD_0000;
        req_valid = 2'b01;
        #1;
        check("abort_grant", 64'(req_ready), 64'(2'b01));
        @(posedge clk); #1;
        req_valid = '0;
        check("abort_rd_en", 64'(read_enable), 64'(1));
        @(posedge clk); #1;
        check("abort_wr_en", 64'(write_enable), 64'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_rst_wr_en", 64'(write_enable), 64'(0));
        check("abort_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("abort_rst_busy", 64'(busy), 64'(0));
        check("abort_rst_read_addr", 64'(read_addr), 64'(0));
        check("abort_rst_write_data", 64'(write_data), 64'(0));
        check("abort_rst_rsp_data", 64'(rsp_data), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_post_wr_en", 64'(write_enable), 64'(0));
        check("abort_post_rsp_valid", 64'(rsp_valid), 64'(0));
        check("abort_post_busy", 64'(busy), 64'(0));
        repeat (3) @(posedge clk);
        #1;

        // Recovery after the abort: a plain read from requester 1.
        single_op(1, CSR_RO, 12'h300, 32'h0, 32'h0000_000F, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_csr_arbiter.md
VX_CSR_ARBITER -- requirements
Module: VX_csr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQS, default 2: number of CSR requesters sharing one CSR data port; legal range 1..8.
REQ-002 SHALL have port clk, input, 1: clock, with one clock domain only; reset is synchronous and active-high.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, NUM_REQS: per-requester request valid.
REQ-005 SHALL have port req_ready, output, NUM_REQS: per-requester accept, one-hot or zero.
REQ-006 SHALL have port req_op, input, NUM_REQS x 2: operation; 01 RW, 10 RS, 11 RC, 00 read-only.
REQ-007 SHALL have port req_addr, input, NUM_REQS x `CSR_ADDR_BITS: CSR address.
REQ-008 SHALL have port req_wid, input, NUM_REQS x `NW_BITS: warp id.
REQ-009 SHALL have port req_uuid, input, NUM_REQS x `UUID_BITS: instruction tag.
REQ-010 SHALL have port req_data, input, NUM_REQS x 32: write operand or set/clear mask.
REQ-011 SHALL have port rsp_valid, input-side handshake output, 1: response valid.
REQ-012 SHALL have port rsp_ready, input, 1: response accept.
REQ-013 SHALL have port rsp_idx, output, clog2(NUM_REQS) (min 1): index of the requester being answered.
REQ-014 SHALL have port rsp_data, output, 32: old CSR value.
REQ-015 SHALL have CSR-side outputs read_enable (1), read_addr, read_wid and read_uuid: the read port of the CSR data block.
REQ-016 SHALL have port read_data, input, 32: combinational CSR read result.
REQ-017 SHALL have CSR-side outputs write_enable (1), write_addr, write_wid, write_uuid and write_data (32): the write port of the CSR data block.
REQ-018 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.

Function
REQ-019 SHALL implement an FSM with states IDLE, READ, WRITE and RSP.
REQ-020 IDLE SHALL, when any req_valid is high, grant one requester round-robin: the lowest index at or above rr_ptr, with wrap-around.
REQ-021 In IDLE, req_ready SHALL be asserted combinationally for the granted index only.
REQ-022 On the grant, the block SHALL latch op/addr/wid/uuid/data and move to READ.
REQ-023 After a grant to index g, rr_ptr SHALL become (g+1) mod NUM_REQS; rr_ptr SHALL be unchanged when there is no grant.
REQ-024 READ SHALL assert read_enable for exactly one cycle with the latched addr/wid/uuid.
REQ-025 READ SHALL capture read_data into old_r.
REQ-026 A write is needed when op==RW, or when op is RS or RC and data!=0.
REQ-027 From READ, the FSM SHALL go to WRITE if a write is needed, else to RSP.
REQ-028 WRITE SHALL assert write_enable for exactly one cycle.
REQ-029 write_data SHALL be: RW -> data; RS -> old_r|data; RC -> old_r&~data.
REQ-030 After WRITE, the FSM SHALL go to RSP.
REQ-031 RSP SHALL hold rsp_valid=1 with stable rsp_idx and rsp_data=old_r until rsp_ready is high, then go to IDLE.
REQ-032 No request SHALL be accepted in the same cycle as a response handshake.
REQ-033 Latency SHALL be: accept at cycle T, read at T+1, write at T+2, rsp_valid from T+3 (from T+2 when no write is needed).
REQ-034 Throughput SHALL be at most one request per 3 cycles (4 cycles with a write) when rsp_ready is held high.
REQ-035 read_enable and write_enable SHALL never be high in the same cycle.
REQ-036 req_ready SHALL be 0 in every state except IDLE.
REQ-037 When NUM_REQS==1, the arbiter SHALL degenerate to pass-through grant, with rr_ptr constant at 0.

Reset
REQ-038 Reset SHALL set state=IDLE and rr_ptr=0, and clear old_r and all latched fields to 0.
REQ-039 During and after reset, all outputs SHALL be 0 (req_ready, rsp_valid, read_enable, write_enable, busy, data/addr buses).
REQ-040 A reset asserted mid-operation SHALL abort it: no write_enable and no rsp_valid in the cycle after reset is deasserted, and the aborted request is dropped.

Structure
REQ-041 Operation encodings (RW/RS/RC/RO) and the state enum SHALL live in a shared package csr_types, imported like fpu_types.
REQ-042 Round-robin selection SHALL be a sub-module VX_rr_arbiter (inputs: requests, enable; outputs: one-hot grant, grant index), instantiated once.
REQ-043 The datapath (RMW mux, latches) and FSM SHALL stay in VX_csr_arbiter.

Verification
REQ-044 The bench SHALL cover single RW: req0 RW addr=CSR_MSCRATCH-like, data=0xA5A5_0000, CSR holding 0x1234 -> read at T+1, write_data=0xA5A5_0000 at T+2, rsp_data=0x1234 with rsp_idx=0 at T+3.
REQ-045 The bench SHALL cover RS/RC: old 0x00F0, RS 0x000F -> write_data 0x00FF; then RC 0x00F0 -> write_data 0x000F; rsp_data 0x00F0 then 0x00FF.
REQ-046 The bench SHALL cover the skip write: RS with data=0 -> no write_enable pulse, rsp_valid at T+2, rsp_data=old.
REQ-047 The bench SHALL cover fairness: req0 and req1 valid continuously -> grant order 0,1,0,1 and neither starves over 8 grants.
REQ-048 The bench SHALL cover backpressure: rsp_ready low for 5 cycles -> rsp_valid/idx/data stable, req_ready=0, busy=1 throughout.
REQ-049 The bench SHALL cover reset mid-op: reset asserted in the WRITE cycle -> next cycle all outputs 0, state IDLE, no response emitted.
